// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: IR field layout, opcodes,
// ALU op codes, FSM state encoding and instruction classification.
package cpu_ctrl_pkg;

  localparam int unsigned IR_W    = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned NREG    = 16;
  localparam int unsigned RegIdxW = 4;

  localparam int unsigned OpcMsb = 31;
  localparam int unsigned OpcLsb = 27;
  localparam int unsigned RaMsb  = 26;
  localparam int unsigned RaLsb  = 23;
  localparam int unsigned RbMsb  = 22;
  localparam int unsigned RbLsb  = 19;
  localparam int unsigned RcMsb  = 18;
  localparam int unsigned RcLsb  = 15;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OpAnd  = 5'b00001;
  localparam opcode_t OpOr   = 5'b00010;
  localparam opcode_t OpAdd  = 5'b00011;
  localparam opcode_t OpSub  = 5'b00100;
  localparam opcode_t OpShr  = 5'b00101;
  localparam opcode_t OpShl  = 5'b00110;
  localparam opcode_t OpRor  = 5'b00111;
  localparam opcode_t OpRol  = 5'b01000;
  localparam opcode_t OpAddi = 5'b01001;
  localparam opcode_t OpAndi = 5'b01010;
  localparam opcode_t OpOri  = 5'b01011;
  localparam opcode_t OpMul  = 5'b01100;
  localparam opcode_t OpDiv  = 5'b01101;
  localparam opcode_t OpNeg  = 5'b01110;
  localparam opcode_t OpNot  = 5'b01111;
  localparam opcode_t OpNop  = 5'b10000;
  localparam opcode_t OpHalt = 5'b10001;

  localparam opcode_t AluNone = 5'b00000;
  localparam opcode_t AluAnd  = 5'b00001;
  localparam opcode_t AluOr   = 5'b00010;
  localparam opcode_t AluAdd  = 5'b00011;

  typedef enum logic [3:0] {
    StReset, StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalted
  } state_t;

  typedef enum logic [2:0] {
    ClsRtype, ClsImm, ClsMulDiv, ClsUnary, ClsNop, ClsHalt, ClsUndef
  } insn_cls_e;

  function automatic insn_cls_e classify(opcode_t opc);
    case (opc)
      OpAnd, OpOr, OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol: return ClsRtype;
      OpAddi, OpAndi, OpOri:                                 return ClsImm;
      OpMul, OpDiv:                                          return ClsMulDiv;
      OpNeg, OpNot:                                          return ClsUnary;
      OpNop:                                                 return ClsNop;
      OpHalt:                                                return ClsHalt;
      default:                                               return ClsUndef;
    endcase
  endfunction

  // Immediate forms reuse the register-form ALU codes; everything else passes through.
  function automatic opcode_t alu_op(opcode_t opc);
    case (opc)
      OpAddi:  return AluAdd;
      OpAndi:  return AluAnd;
      OpOri:   return AluOr;
      default: return opc;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and data_path (slave).
interface control_sequencer_if
  import cpu_ctrl_pkg::*;
();

  logic [IR_W-1:0] ir;
  logic            Stop;
  logic [OP_W-1:0] op;
  logic [NREG-1:0] Rout_sel;
  logic [NREG-1:0] Rin_sel;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Cout;
  logic Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin;
  logic Run, Illegal;

  modport master (
    input  ir, Stop,
    output op, Rout_sel, Rin_sel,
    output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Cout,
    output Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin, Run, Illegal
  );

  modport slave (
    output ir, Stop,
    input  op, Rout_sel, Rin_sel,
    input  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Cout,
    input  Zlowin, ZHighin, Zlowout, Zhighout, HIin, LOin, Run, Illegal
  );

endinterface

// File: rtl/reg_sel_decoder.sv
// 4-to-16 one-hot register select decoder with enable; all zeros when disabled.
module reg_sel_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic               en_i,
  input  logic [RegIdxW-1:0] idx_i,
  output logic [NREG-1:0]    sel_o
);

  always_comb begin
    sel_o = '0;
    if (en_i) sel_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving data_path control strobes.
// Outputs are Moore decodes of the state register and the IR fields.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic                 Clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  state_t             state_q, state_d, fetch_st;
  opcode_t            opc;
  logic [RegIdxW-1:0] ra, rb, rc;
  insn_cls_e          cls;
  logic               exec, muldiv;
  logic               rout_en, rin_en;
  logic [RegIdxW-1:0] rout_idx;
  logic               unused_ir;

  assign opc       = bus.ir[OpcMsb:OpcLsb];
  assign ra        = bus.ir[RaMsb:RaLsb];
  assign rb        = bus.ir[RbMsb:RbLsb];
  assign rc        = bus.ir[RcMsb:RcLsb];
  assign unused_ir = ^bus.ir[RcLsb-1:0];
  assign cls       = classify(opc);
  assign exec      = cls inside {ClsRtype, ClsImm, ClsMulDiv, ClsUnary};
  assign muldiv    = (cls == ClsMulDiv);
  // Every return to fetch is a Stop decision point.
  assign fetch_st  = bus.Stop ? StIdle : StT0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = fetch_st;
      StIdle:   if (!bus.Stop) state_d = StT0;
      StT0:     state_d = StT1;
      StT1:     state_d = StT2;
      StT2:     state_d = StT3;
      StT3: begin
        if (exec)                state_d = StT4;
        else if (cls == ClsHalt) state_d = StHalted;
        else                     state_d = fetch_st;
      end
      StT4:     state_d = StT5;
      StT5:     state_d = muldiv ? StT6 : fetch_st;
      StT6:     state_d = fetch_st;
      StHalted: state_d = StHalted;
      default:  state_d = StReset;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state_q <= StReset;
    else        state_q <= state_d;
  end

  always_comb begin
    bus.op      = AluNone;
    bus.PCout   = 1'b0;
    bus.PCin    = 1'b0;
    bus.IncPC   = 1'b0;
    bus.MARin   = 1'b0;
    bus.Read    = 1'b0;
    bus.MDRin   = 1'b0;
    bus.MDRout  = 1'b0;
    bus.IRin    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Cout    = 1'b0;
    bus.Zlowin  = 1'b0;
    bus.ZHighin = 1'b0;
    bus.Zlowout = 1'b0;
    bus.Zhighout = 1'b0;
    bus.HIin    = 1'b0;
    bus.LOin    = 1'b0;
    bus.Run     = 1'b0;
    bus.Illegal = 1'b0;
    rout_en     = 1'b0;
    rout_idx    = rb;
    rin_en      = 1'b0;
    unique case (state_q)
      StT0: begin
        bus.Run    = 1'b1;
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      StT1: begin
        bus.Run     = 1'b1;
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      StT2: begin
        bus.Run    = 1'b1;
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      StT3: begin
        bus.Run     = 1'b1;
        rout_en     = exec;
        bus.Yin     = exec;
        bus.Illegal = (cls == ClsUndef);
      end
      StT4: begin
        bus.Run     = 1'b1;
        bus.op      = alu_op(opc);
        bus.Zlowin  = 1'b1;
        bus.ZHighin = muldiv;
        if (cls == ClsImm) begin
          bus.Cout = 1'b1;
        end else begin
          rout_en  = 1'b1;
          rout_idx = (cls == ClsUnary) ? rb : rc;
        end
      end
      StT5: begin
        bus.Run     = 1'b1;
        bus.Zlowout = 1'b1;
        bus.LOin    = muldiv;
        rin_en      = !muldiv;
      end
      StT6: begin
        bus.Run      = 1'b1;
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  reg_sel_decoder u_rout_dec (
    .en_i  (rout_en),
    .idx_i (rout_idx),
    .sel_o (bus.Rout_sel)
  );

  reg_sel_decoder u_rin_dec (
    .en_i  (rin_en),
    .idx_i (ra),
    .sel_o (bus.Rin_sel)
  );

  bus_drv_onehot_a: assert property (@(posedge Clock) disable iff (!clear)
      $onehot0({bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.Cout, |bus.Rout_sel})
      && $onehot0(bus.Rout_sel));

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected strobe schedules built from the
// instruction-class rules, compared every cycle against the sequencer outputs.
module tb_control_sequencer;

  logic Clock;
  logic clear;

  control_sequencer_if bus_if ();

  control_sequencer dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] rout;
    logic [15:0] rin;
    logic pcout, pcin, incpc, marin, rd, mdrin, mdrout, irin, yin, cout;
    logic zlowin, zhighin, zlowout, zhighout, hiin, loin, run, illegal;
  } ctl_t;

  int   n_chk = 0;
  int   n_bad = 0;
  ctl_t exp_a [7];
  ctl_t obs_a [7];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t s;
    s.op = bus_if.op;           s.rout = bus_if.Rout_sel;   s.rin = bus_if.Rin_sel;
    s.pcout = bus_if.PCout;     s.pcin = bus_if.PCin;       s.incpc = bus_if.IncPC;
    s.marin = bus_if.MARin;     s.rd = bus_if.Read;         s.mdrin = bus_if.MDRin;
    s.mdrout = bus_if.MDRout;   s.irin = bus_if.IRin;       s.yin = bus_if.Yin;
    s.cout = bus_if.Cout;       s.zlowin = bus_if.Zlowin;   s.zhighin = bus_if.ZHighin;
    s.zlowout = bus_if.Zlowout; s.zhighout = bus_if.Zhighout;
    s.hiin = bus_if.HIin;       s.loin = bus_if.LOin;
    s.run = bus_if.Run;         s.illegal = bus_if.Illegal;
    return s;
  endfunction

  // Reference schedule for one instruction; returns its length in cycles.
  function automatic int build(input logic [31:0] w);
    int         opc;
    int         ra, rb, rc, n;
    bit         rtype, imm, md, un, exec;
    logic [4:0] aop;
    opc   = int'(w[31:27]);
    ra    = int'(w[26:23]);
    rb    = int'(w[22:19]);
    rc    = int'(w[18:15]);
    rtype = (opc >= 1 && opc <= 8);
    imm   = (opc >= 9 && opc <= 11);
    md    = (opc == 12 || opc == 13);
    un    = (opc == 14 || opc == 15);
    exec  = rtype || imm || md || un;
    if (opc == 9)       aop = 5'd3;
    else if (opc == 10) aop = 5'd1;
    else if (opc == 11) aop = 5'd2;
    else                aop = w[31:27];
    n = !exec ? 4 : (md ? 7 : 6);
    for (int k = 0; k < 7; k++) begin
      exp_a[k] = '0;
      exp_a[k].run = (k < n);
    end
    exp_a[0].pcout = 1'b1; exp_a[0].marin = 1'b1; exp_a[0].incpc = 1'b1;
    exp_a[0].zlowin = 1'b1;
    exp_a[1].zlowout = 1'b1; exp_a[1].pcin = 1'b1; exp_a[1].rd = 1'b1;
    exp_a[1].mdrin = 1'b1;
    exp_a[2].mdrout = 1'b1; exp_a[2].irin = 1'b1;
    exp_a[3].illegal = !exec && opc != 16 && opc != 17;
    if (exec) begin
      exp_a[3].rout    = 16'h1 << rb;
      exp_a[3].yin     = 1'b1;
      exp_a[4].op      = aop;
      exp_a[4].zlowin  = 1'b1;
      exp_a[4].zhighin = md;
      if (imm)     exp_a[4].cout = 1'b1;
      else if (un) exp_a[4].rout = 16'h1 << rb;
      else         exp_a[4].rout = 16'h1 << rc;
      exp_a[5].zlowout = 1'b1;
      if (md) begin
        exp_a[5].loin     = 1'b1;
        exp_a[6].zhighout = 1'b1;
        exp_a[6].hiin     = 1'b1;
      end else begin
        exp_a[5].rin = 16'h1 << ra;
      end
    end
    return n;
  endfunction

  // Must be entered so that the next falling edge lies in T0 of this instruction.
  task automatic run_instr(input logic [31:0] w, input bit stop_mid, input int abort_at,
                           input string name);
    int   n;
    ctl_t o;
    n = build(w);
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      o        = sample();
      obs_a[k] = o;
      chk($sformatf("%s c%0d", name, k), 64'(o), 64'(exp_a[k]));
      if (k == abort_at) begin
        #2 clear = 1'b0;
        #1 chk({name, " async clear"}, 64'(sample()), 64'd0);
        return;
      end
      if (k == 1 && stop_mid) bus_if.Stop = 1'b1;
      if (k == 2) bus_if.ir = w;
    end
  endtask

  task automatic idle_phase(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      chk($sformatf("%s idle%0d", name, i), 64'(sample()), 64'd0);
    end
    bus_if.Stop = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] opc;
    int         pick;
    pick = int'($urandom_range(0, 20));
    if (pick <= 16) opc = 5'(pick);
    else            opc = 5'($urandom_range(18, 31));
    return {opc, 27'($urandom())};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [15:0] rin_or;
    int          ill_cnt;
    bit          stp;
    clear       = 1'b0;
    bus_if.Stop = 1'b0;
    bus_if.ir   = '0;

    @(negedge Clock);
    chk("reset outputs", 64'(sample()), 64'd0);
    @(negedge Clock);
    clear = 1'b1;

    run_instr(32'h1091_8000, 1'b0, -1, "or");
    chk("or T3 rout", 64'(obs_a[3].rout), 64'h0004);
    chk("or T4 rout", 64'(obs_a[4].rout), 64'h0008);
    chk("or T4 op", 64'(obs_a[4].op), 64'h2);
    chk("or T5 rin", 64'(obs_a[5].rin), 64'h0002);

    run_instr(32'h4A2F_FFFD, 1'b0, -1, "addi");
    chk("addi T4 cout", 64'(obs_a[4].cout), 64'h1);
    chk("addi T4 rout", 64'(obs_a[4].rout), 64'h0);
    chk("addi T4 op", 64'(obs_a[4].op), 64'h3);
    chk("addi T5 rin", 64'(obs_a[5].rin), 64'h0010);

    w = {5'b01100, 4'd0, 4'd6, 4'd7, 15'd0};
    run_instr(w, 1'b0, -1, "mul");
    rin_or = '0;
    for (int k = 0; k < 7; k++) rin_or |= obs_a[k].rin;
    chk("mul T4 zhighin", 64'(obs_a[4].zhighin & obs_a[4].zlowin), 64'h1);
    chk("mul T5 loin", 64'(obs_a[5].loin), 64'h1);
    chk("mul T6 hiin", 64'(obs_a[6].hiin), 64'h1);
    chk("mul rin never", 64'(rin_or), 64'h0);

    run_instr(32'hF800_0000, 1'b0, -1, "undef");
    ill_cnt = 0;
    for (int k = 0; k < 4; k++) ill_cnt += int'(obs_a[k].illegal);
    chk("undef illegal cycles", 64'(ill_cnt), 64'd1);

    run_instr({5'b00011, 27'($urandom())}, 1'b0, 4, "abort");
    @(negedge Clock);
    clear = 1'b1;
    run_instr({5'b10000, 27'd0}, 1'b0, -1, "post abort");
    chk("post abort T0", 64'({obs_a[0].pcout, obs_a[0].marin, obs_a[0].incpc}), 64'h7);

    for (int i = 0; i < 80; i++) begin
      stp = ($urandom_range(0, 9) == 0);
      run_instr(rand_instr(), stp, -1, $sformatf("rnd%0d", i));
      if (stp) idle_phase(int'($urandom_range(1, 4)), $sformatf("rnd%0d", i));
    end

    run_instr({5'b10001, 27'd0}, 1'b0, -1, "halt");
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      chk($sformatf("halted%0d", i), 64'(sample()), 64'd0);
    end
    clear       = 1'b0;
    bus_if.Stop = 1'b1;
    @(negedge Clock);
    clear = 1'b1;
    idle_phase(3, "stop after clear");
    run_instr({5'b00001, 27'($urandom())}, 1'b0, -1, "resume");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
